// File: rtl/tlp_tx_pkg.sv
// Shared types and constants for the MicroBlaze-to-PCIe TLP transmit framer.
package tlp_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BUF = 2'd1,
    ST_SEND     = 2'd2,
    ST_FLUSH    = 2'd3
  } tx_state_t;

  // Minimum core TX buffer count before a TLP may be started.
  localparam logic [5:0] BUF_AV_MIN = 6'd1;
  // Every beat carries a full 32-bit word.
  localparam logic [3:0] TKEEP_ALL = 4'hF;
  // Bit positions inside s_axis_tx_tuser.
  localparam int TUSER_SRC_DSC = 3;
  localparam int TUSER_STREAM  = 2;

  // Build the tuser vector for one beat; streaming is never used.
  function automatic logic [3:0] tuser_beat(input logic src_dsc);
    logic [3:0] u;
    u = 4'b0000;
    u[TUSER_SRC_DSC] = src_dsc;
    u[TUSER_STREAM]  = 1'b0;
    return u;
  endfunction

endpackage

// File: rtl/tlp_tx_fifo.sv
// Packet FIFO: first-word-fall-through read, write pointer that can be
// committed at a packet end or rewound to the last commit point, and a
// count of complete packets held.
module tlp_tx_fifo #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [31:0]              wr_data,
  input  logic                     wr_last,
  input  logic                     rewind,
  input  logic                     rd_en,
  output logic [31:0]              rd_data,
  output logic                     rd_last,
  output logic                     full,
  input  logic                     pkt_done,
  output logic [$clog2(DEPTH):0]   pkt_count
);

  localparam int AW = $clog2(DEPTH);

  logic [32:0] mem [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] commit_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [AW:0] pkt_count_r;
  logic        commit_s;

  assign commit_s  = wr_en && wr_last && !rewind;
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_data   = mem[rd_ptr_r[AW-1:0]][31:0];
  assign rd_last   = mem[rd_ptr_r[AW-1:0]][32];
  assign pkt_count = pkt_count_r;

  // Storage array: word plus its tlast flag; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rewind) begin
      mem[wr_ptr_r[AW-1:0]] <= {wr_last, wr_data};
    end
  end

  // Pointer bookkeeping; the extra MSB separates full from empty on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= {(AW+1){1'b0}};
      commit_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r     <= {(AW+1){1'b0}};
    end else begin
      if (rewind) begin
        wr_ptr_r <= commit_ptr_r;
      end else if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
        if (wr_last) begin
          commit_ptr_r <= wr_ptr_r + (AW+1)'(1);
        end
      end
      if (rd_en) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // Complete-packet count; a simultaneous commit and completion cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_r <= {(AW+1){1'b0}};
    end else begin
      case ({commit_s, pkt_done})
        2'b10:   pkt_count_r <= pkt_count_r + (AW+1)'(1);
        2'b01:   pkt_count_r <= pkt_count_r - (AW+1)'(1);
        default: pkt_count_r <= pkt_count_r;
      endcase
    end
  end

endmodule

// File: rtl/tlp_tx_framer.sv
// Store-and-forward framer: buffers TLPs from MicroBlaze, drops oversize
// packets, and streams complete TLPs to the PCIe core TX interface.
module tlp_tx_framer
  import tlp_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 512,
  parameter int MAX_TLP_DW = 132
) (
  input  logic        user_clk,
  input  logic        user_reset,
  input  logic        user_lnk_up,
  input  logic [31:0] s_axis_mb_tdata,
  input  logic        s_axis_mb_tvalid,
  input  logic        s_axis_mb_tlast,
  output logic        s_axis_mb_tready,
  output logic [31:0] s_axis_tx_tdata,
  output logic [3:0]  s_axis_tx_tkeep,
  output logic [3:0]  s_axis_tx_tuser,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  input  logic        s_axis_tx_tready,
  input  logic [5:0]  tx_buf_av,
  input  logic        tx_cfg_req,
  output logic        tx_cfg_gnt,
  input  logic        tx_err_drop,
  output logic [15:0] drop_count,
  output logic        oversize
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(MAX_TLP_DW + 1);

  tx_state_t     state_r, state_s;
  logic          discard_r;
  logic [CW-1:0] word_cnt_r;
  logic          oversize_r;
  logic [15:0]   drop_count_r;
  logic          mb_accept_s, wr_en_s, rewind_s, fifo_full_s;
  logic          rd_en_s, pkt_done_s, head_last_s;
  logic [31:0]   head_data_s;
  logic [PW-1:0] pkt_count_s;
  logic          tx_valid_s, tx_last_s, tx_dsc_s;

  // In discard mode every word is swallowed, so ready ignores fullness.
  assign s_axis_mb_tready = !user_reset && (discard_r || !fifo_full_s);
  assign mb_accept_s      = s_axis_mb_tvalid && s_axis_mb_tready;
  assign rewind_s         = mb_accept_s && !discard_r && !s_axis_mb_tlast &&
                            (word_cnt_r == CW'(MAX_TLP_DW - 1));
  assign wr_en_s          = mb_accept_s && !discard_r && !rewind_s;

  tlp_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (user_clk),
    .rst       (user_reset),
    .wr_en     (wr_en_s),
    .wr_data   (s_axis_mb_tdata),
    .wr_last   (s_axis_mb_tlast),
    .rewind    (rewind_s),
    .rd_en     (rd_en_s),
    .rd_data   (head_data_s),
    .rd_last   (head_last_s),
    .full      (fifo_full_s),
    .pkt_done  (pkt_done_s),
    .pkt_count (pkt_count_s)
  );

  // Ingress length tracking, oversize discard mode and sticky flag.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      word_cnt_r <= {CW{1'b0}};
      discard_r  <= 1'b0;
      oversize_r <= 1'b0;
    end else if (mb_accept_s) begin
      if (discard_r) begin
        discard_r <= !s_axis_mb_tlast;
      end else if (s_axis_mb_tlast) begin
        word_cnt_r <= {CW{1'b0}};
      end else if (rewind_s) begin
        word_cnt_r <= {CW{1'b0}};
        discard_r  <= 1'b1;
        oversize_r <= 1'b1;
      end else begin
        word_cnt_r <= word_cnt_r + CW'(1);
      end
    end
  end

  // Egress state register.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Egress next state and beat control; a link loss truncates the TLP.
  always_comb begin
    state_s    = state_r;
    rd_en_s    = 1'b0;
    pkt_done_s = 1'b0;
    tx_valid_s = 1'b0;
    tx_last_s  = 1'b0;
    tx_dsc_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((pkt_count_s != {PW{1'b0}}) && user_lnk_up) begin
          state_s = ST_WAIT_BUF;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_BUF: begin
        if (!user_lnk_up) begin
          state_s = ST_IDLE;
        end else if ((tx_buf_av >= BUF_AV_MIN) && !tx_cfg_req) begin
          state_s = ST_SEND;
        end else begin
          state_s = ST_WAIT_BUF;
        end
      end
      ST_SEND: begin
        tx_valid_s = 1'b1;
        tx_dsc_s   = !user_lnk_up;
        tx_last_s  = head_last_s || !user_lnk_up;
        rd_en_s    = s_axis_tx_tready;
        if (s_axis_tx_tready) begin
          if (head_last_s) begin
            pkt_done_s = 1'b1;
            state_s    = ST_IDLE;
          end else if (!user_lnk_up) begin
            state_s = ST_FLUSH;
          end else begin
            state_s = ST_SEND;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_FLUSH: begin
        rd_en_s = 1'b1;
        if (head_last_s) begin
          pkt_done_s = 1'b1;
          state_s    = ST_IDLE;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Saturating count of core-reported TLP drops.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      drop_count_r <= 16'h0000;
    end else if (tx_err_drop && (drop_count_r != 16'hFFFF)) begin
      drop_count_r <= drop_count_r + 16'h0001;
    end
  end

  assign s_axis_tx_tvalid = tx_valid_s && !user_reset;
  assign s_axis_tx_tlast  = tx_last_s && !user_reset;
  assign s_axis_tx_tuser  = user_reset ? 4'b0000 : tuser_beat(tx_dsc_s);
  assign s_axis_tx_tdata  = tx_valid_s ? head_data_s : 32'h0000_0000;
  assign s_axis_tx_tkeep  = TKEEP_ALL;
  assign tx_cfg_gnt       = user_reset || (state_r == ST_IDLE) || (state_r == ST_WAIT_BUF);
  assign drop_count       = drop_count_r;
  assign oversize         = oversize_r;

endmodule

// File: tb/tb_tlp_tx_framer.sv
// Directed and randomized bench for tlp_tx_framer with a packet-level model.
module tb_tlp_tx_framer;
  import tlp_tx_pkg::*;

  localparam int DEPTH = 16;
  localparam int MAX   = 12;

  logic        clk;
  logic        user_reset, user_lnk_up;
  logic [31:0] mb_tdata;
  logic        mb_tvalid, mb_tlast, mb_tready;
  logic [31:0] tx_tdata;
  logic [3:0]  tx_tkeep, tx_tuser;
  logic        tx_tlast, tx_tvalid, tx_tready;
  logic        tx_tready_dir, tx_tready_rnd, rand_rdy;
  logic [5:0]  tx_buf_av;
  logic        tx_cfg_req, tx_cfg_gnt, tx_err_drop;
  logic [15:0] drop_count;
  logic        oversize;

  typedef struct { logic [31:0] data; logic last; logic [3:0] user; logic [3:0] keep; logic gnt; int cyc; } beat_t;
  typedef struct { logic [31:0] data; logic last; logic [3:0] user; } exp_t;

  beat_t       rx_q[$];
  exp_t        exp_q[$];
  logic [31:0] pkt_words[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          commit_cyc = 0;

  assign tx_tready = rand_rdy ? tx_tready_rnd : tx_tready_dir;

  tlp_tx_framer #(.FIFO_DEPTH(DEPTH), .MAX_TLP_DW(MAX)) dut (
    .user_clk(clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
    .s_axis_mb_tdata(mb_tdata), .s_axis_mb_tvalid(mb_tvalid), .s_axis_mb_tlast(mb_tlast),
    .s_axis_mb_tready(mb_tready),
    .s_axis_tx_tdata(tx_tdata), .s_axis_tx_tkeep(tx_tkeep), .s_axis_tx_tuser(tx_tuser),
    .s_axis_tx_tlast(tx_tlast), .s_axis_tx_tvalid(tx_tvalid), .s_axis_tx_tready(tx_tready),
    .tx_buf_av(tx_buf_av), .tx_cfg_req(tx_cfg_req), .tx_cfg_gnt(tx_cfg_gnt),
    .tx_err_drop(tx_err_drop), .drop_count(drop_count), .oversize(oversize)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tx_tready_rnd = 1'b1;
    forever begin
      @(negedge clk);
      tx_tready_rnd = 1'($urandom_range(0, 1));
    end
  end

  // Beat monitor: records every TX handshake with its cycle number.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!user_reset && tx_tvalid && tx_tready)
      rx_q.push_back('{data: tx_tdata, last: tx_tlast, user: tx_tuser, keep: tx_tkeep, gnt: tx_cfg_gnt, cyc: cyc});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_pkt(input int len, input bit gaps, input bit model);
    int t;
    pkt_words.delete();
    for (int i = 0; i < len; i++) begin
      logic [31:0] w;
      w = $urandom();
      if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
      mb_tdata = w; mb_tvalid = 1'b1; mb_tlast = (i == len - 1);
      t = 0;
      while (!mb_tready && t < 500) begin @(negedge clk); t++; end
      if (t >= 500) begin
        check("mb_ready_timeout", 64'(mb_tready), 64'd1);
        mb_tvalid = 1'b0; mb_tlast = 1'b0;
        return;
      end
      @(negedge clk);
      mb_tvalid = 1'b0; mb_tlast = 1'b0;
      pkt_words.push_back(w);
      if (model && len <= MAX) exp_q.push_back('{data: w, last: (i == len - 1), user: 4'h0});
    end
    commit_cyc = cyc;
  endtask

  task automatic wait_tvalid(input string tag);
    int t = 0;
    while (!tx_tvalid && t < 200) begin @(negedge clk); t++; end
    check(tag, 64'(tx_tvalid), 64'd1);
  endtask

  task automatic compare_all(input string tag);
    int t = 0;
    while (rx_q.size() < exp_q.size() && t < 3000) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    check({tag, "_beat_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      beat_t b; exp_t e;
      b = rx_q.pop_front(); e = exp_q.pop_front();
      check({tag, "_data"}, 64'(b.data), 64'(e.data));
      check({tag, "_last"}, 64'(b.last), 64'(e.last));
      check({tag, "_user"}, 64'(b.user), 64'(e.user));
      check({tag, "_keep"}, 64'(b.keep), 64'h0F);
    end
    rx_q.delete(); exp_q.delete();
  endtask

  initial begin
    user_reset = 1'b1; user_lnk_up = 1'b0;
    mb_tdata = 32'h0; mb_tvalid = 1'b0; mb_tlast = 1'b0;
    tx_tready_dir = 1'b1; rand_rdy = 1'b0;
    tx_buf_av = 6'd63; tx_cfg_req = 1'b0; tx_err_drop = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_tvalid", 64'(tx_tvalid), 64'd0);
    check("rst_tlast", 64'(tx_tlast), 64'd0);
    check("rst_tuser", 64'(tx_tuser), 64'd0);
    check("rst_tkeep", 64'(tx_tkeep), 64'hF);
    check("rst_mb_tready", 64'(mb_tready), 64'd0);
    check("rst_gnt", 64'(tx_cfg_gnt), 64'd1);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_oversize", 64'(oversize), 64'd0);
    user_reset = 1'b0; user_lnk_up = 1'b1;
    @(negedge clk);
    check("idle_mb_tready", 64'(mb_tready), 64'd1);

    // Fixed 3DW TLP
    mb_tdata = 32'h4A00_0001; mb_tvalid = 1'b1; mb_tlast = 1'b0; @(negedge clk);
    mb_tdata = 32'h0000_0100; @(negedge clk);
    mb_tdata = 32'hDEAD_BEEF; mb_tlast = 1'b1; @(negedge clk);
    mb_tvalid = 1'b0; mb_tlast = 1'b0; commit_cyc = cyc;
    exp_q.push_back('{data: 32'h4A00_0001, last: 1'b0, user: 4'h0});
    exp_q.push_back('{data: 32'h0000_0100, last: 1'b0, user: 4'h0});
    exp_q.push_back('{data: 32'hDEAD_BEEF, last: 1'b1, user: 4'h0});
    for (int t = 0; t < 50 && rx_q.size() < 3; t++) @(negedge clk);
    check("3dw_beats", 64'(rx_q.size()), 64'd3);
    if (rx_q.size() >= 3) begin
      check("3dw_latency", 64'((rx_q[0].cyc - commit_cyc) >= 2), 64'd1);
      check("3dw_contig1", 64'(rx_q[1].cyc), 64'(rx_q[0].cyc + 1));
      check("3dw_contig2", 64'(rx_q[2].cyc), 64'(rx_q[0].cyc + 2));
      for (int i = 0; i < 3; i++) check("3dw_gnt", 64'(rx_q[i].gnt), 64'd0);
    end
    compare_all("3dw");

    // Random lengths, ingress gaps and TX backpressure; includes exactly MAX
    rand_rdy = 1'b1;
    for (int p = 0; p < 10; p++) send_pkt($urandom_range(1, MAX), 1'b1, 1'b1);
    send_pkt(MAX, 1'b1, 1'b1);
    compare_all("rand");
    check("max_len_no_oversize", 64'(oversize), 64'd0);

    // Oversize TLP then a 4DW TLP
    send_pkt(MAX + 4, 1'b0, 1'b1);
    send_pkt(4, 1'b1, 1'b1);
    check("oversize_flag", 64'(oversize), 64'd1);
    compare_all("oversize");
    rand_rdy = 1'b0; tx_tready_dir = 1'b1;

    // No TX buffers: hold in WAIT_BUF
    tx_buf_av = 6'd0;
    send_pkt(2, 1'b0, 1'b1);
    repeat (20) begin
      @(negedge clk);
      check("wait_buf_state", 64'(dut.state_r), 64'(ST_WAIT_BUF));
      check("wait_buf_tvalid", 64'(tx_tvalid), 64'd0);
    end
    tx_buf_av = 6'd1;
    @(negedge clk);
    check("buf_av_send_state", 64'(dut.state_r), 64'(ST_SEND));
    check("buf_av_tvalid", 64'(tx_tvalid), 64'd1);
    tx_buf_av = 6'd63;
    compare_all("buf_av");

    // Link loss on beat 2 of an 8DW TLP
    tx_tready_dir = 1'b0;
    send_pkt(8, 1'b0, 1'b0);
    wait_tvalid("lnk_first_beat");
    tx_tready_dir = 1'b1;
    @(negedge clk);
    user_lnk_up = 1'b0;
    #1;
    check("lnk_beat2_tvalid", 64'(tx_tvalid), 64'd1);
    check("lnk_beat2_tlast", 64'(tx_tlast), 64'd1);
    check("lnk_beat2_tuser", 64'(tx_tuser), 64'h8);
    exp_q.push_back('{data: pkt_words[0], last: 1'b0, user: 4'h0});
    exp_q.push_back('{data: pkt_words[1], last: 1'b1, user: 4'h8});
    repeat (15) @(negedge clk);
    check("lnk_pkt_count", 64'(dut.pkt_count_s), 64'd0);
    check("lnk_state_idle", 64'(dut.state_r), 64'(ST_IDLE));
    compare_all("lnk_drop");
    user_lnk_up = 1'b1;
    send_pkt(5, 1'b0, 1'b1);
    compare_all("lnk_return");

    // Fill FIFO with the link down, then drain one word
    user_lnk_up = 1'b0;
    send_pkt(8, 1'b0, 1'b1);
    send_pkt(8, 1'b0, 1'b1);
    @(negedge clk);
    check("full_mb_tready", 64'(mb_tready), 64'd0);
    tx_tready_dir = 1'b0;
    user_lnk_up = 1'b1;
    wait_tvalid("full_first_beat");
    check("full_still_full", 64'(mb_tready), 64'd0);
    tx_tready_dir = 1'b1;
    @(negedge clk);
    tx_tready_dir = 1'b0;
    check("full_one_read_ready", 64'(mb_tready), 64'd1);
    tx_tready_dir = 1'b1;
    send_pkt(8, 1'b0, 1'b1);
    compare_all("wrap");

    // drop_count counting and saturation
    tx_err_drop = 1'b1; @(negedge clk);
    tx_err_drop = 1'b0; @(negedge clk);
    tx_err_drop = 1'b1; @(negedge clk);
    @(negedge clk);
    tx_err_drop = 1'b0; @(negedge clk);
    check("drop_count_3", 64'(drop_count), 64'd3);
    tx_err_drop = 1'b1;
    repeat (1000) @(negedge clk);
    tx_err_drop = 1'b0;
    check("drop_count_1003", 64'(drop_count), 64'd1003);
    tx_err_drop = 1'b1;
    repeat (69000) @(negedge clk);
    tx_err_drop = 1'b0;
    @(negedge clk);
    check("drop_count_sat", 64'(drop_count), 64'hFFFF);

    // Reset with a stored TLP and a partial one in flight
    user_lnk_up = 1'b0;
    send_pkt(3, 1'b0, 1'b0);
    mb_tdata = 32'h1111_2222; mb_tvalid = 1'b1; mb_tlast = 1'b0;
    repeat (2) @(negedge clk);
    mb_tvalid = 1'b0;
    user_reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_drop_count", 64'(drop_count), 64'd0);
    check("rst2_oversize", 64'(oversize), 64'd0);
    check("rst2_mb_tready", 64'(mb_tready), 64'd0);
    check("rst2_tvalid", 64'(tx_tvalid), 64'd0);
    user_reset = 1'b0; user_lnk_up = 1'b1;
    repeat (30) @(negedge clk);
    check("rst2_no_beats", 64'(rx_q.size()), 64'd0);
    check("rst2_pkt_count", 64'(dut.pkt_count_s), 64'd0);
    send_pkt(3, 1'b0, 1'b1);
    compare_all("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tlp_tx_framer.md
TLP_TX_FRAMER -- requirements
Module: tlp_tx_framer

Interface
REQ-001 Parameter FIFO_DEPTH, default 512, sets FIFO depth in 32-bit words (power of two).
REQ-002 Parameter MAX_TLP_DW, default 132, sets the maximum accepted TLP length in words; it SHALL be <= FIFO_DEPTH.
REQ-003 Clocking and reset: one clock, user_clk; reset user_reset is synchronous and active-high.
REQ-004 user_clk  in  1  sole clock, PCIe core user clock.
REQ-005 user_reset  in  1  synchronous active-high reset.
REQ-006 user_lnk_up  in  1  PCIe link up.
REQ-007 s_axis_mb_tdata / tvalid / tlast  in  32/1/1  MicroBlaze TLP words.
REQ-008 s_axis_mb_tready  out  1  MicroBlaze-side ready.
REQ-009 s_axis_tx_tdata / tkeep / tuser / tlast / tvalid  out  32/4/4/1/1  PCIe core TX stream.
REQ-010 s_axis_tx_tready  in  1  PCIe core TX ready.
REQ-011 tx_buf_av  in  6  core TX buffers available.
REQ-012 tx_cfg_req  in  1  core requests the TX path.
REQ-013 tx_cfg_gnt  out  1  grant to the core.
REQ-014 tx_err_drop  in  1  core dropped a TLP.
REQ-015 drop_count  out  16  saturating count of tx_err_drop pulses.
REQ-016 oversize  out  1  sticky flag: an oversize TLP was discarded.

Function
REQ-017 The block SHALL store and forward: a TLP is never presented to the core until its tlast word is accepted into the FIFO.
REQ-018 s_axis_mb_tready SHALL be 1 when the FIFO is not full, or when the block is in discard mode.
REQ-019 A word SHALL be written on tvalid&&tready. An accepted tlast SHALL commit the packet and increment pkt_count.
REQ-020 If a packet's word count reaches MAX_TLP_DW without tlast, the write pointer SHALL rewind to the packet start and oversize SHALL be set. Following words up to and including tlast SHALL be accepted and dropped.
REQ-021 The egress FSM SHALL have the states IDLE, WAIT_BUF, SEND and FLUSH.
REQ-022 IDLE->WAIT_BUF when pkt_count>0 and user_lnk_up=1.
REQ-023 WAIT_BUF->SEND when tx_buf_av>=BUF_AV_MIN (1) and tx_cfg_req=0.
REQ-024 In SEND: tvalid=1 continuously (no gaps), tdata = FIFO head, tkeep=4'hF, tuser=4'b0000; the head advances on tvalid&&tready.
REQ-025 The SEND handshake on the tlast word SHALL return to IDLE and decrement pkt_count.
REQ-026 A commit and a send-complete in the same cycle SHALL leave pkt_count unchanged.
REQ-027 If user_lnk_up falls in SEND, the current beat SHALL be driven with tlast=1 and tuser[3]=1 (src_dsc). After that beat completes, the FSM SHALL enter FLUSH.
REQ-028 FLUSH SHALL discard the rest of that packet at one word per cycle, decrement pkt_count, then go to IDLE.
REQ-029 tx_cfg_gnt SHALL be 1 in IDLE and WAIT_BUF and 0 in SEND and FLUSH.
REQ-030 Latency: the first tx beat SHALL be valid no earlier than 2 cycles after the committing tlast, with tx_buf_av and tx_cfg_req permitting.
REQ-031 drop_count SHALL increment once per cycle with tx_err_drop=1 and saturate at 16'hFFFF.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-033 While user_reset=1: s_axis_tx_tvalid=0, tlast=0, tuser=0, tkeep=4'hF, s_axis_mb_tready=0, tx_cfg_gnt=1, drop_count=0, oversize=0, state=IDLE, FIFO empty, pkt_count=0.
REQ-034 Reset mid-packet on either side SHALL discard all partial and stored data with no further output beats.

Structure
REQ-035 Package tlp_tx_pkg SHALL hold: the FSM state enum, BUF_AV_MIN, TKEEP_ALL, and the TUSER_SRC_DSC and TUSER_STREAM bit indices.
REQ-036 Sub-module tlp_tx_fifo SHALL be a synchronous FWFT FIFO with commit/rewind on the write pointer and pkt_count. The FSM and counters SHALL stay in tlp_tx_framer.

Verification
REQ-037 3DW TLP {0x4A000001,0x00000100,0xDEADBEEF} with tx_tready=1 -> three contiguous beats, tlast on beat 3, tuser=0, tkeep=F, tx_cfg_gnt=0 during the beats.
REQ-038 Packet of MAX_TLP_DW+4 words without tlast until the final word, then a 4DW TLP -> oversize=1, only the 4DW TLP is emitted.
REQ-039 tx_buf_av=0 for 20 cycles with a committed packet -> FSM stays in WAIT_BUF with tvalid=0; tx_buf_av=1 -> SEND within 1 cycle.
REQ-040 user_lnk_up dropped on beat 2 of an 8DW TLP -> beat 2 has tlast=1 and tuser[3]=1, pkt_count returns to 0, the next TLP is sent intact after the link returns.
REQ-041 70000 tx_err_drop pulses -> drop_count=16'hFFFF; then user_reset -> drop_count=0.
REQ-042 Fill the FIFO to FIFO_DEPTH words -> s_axis_mb_tready=0; one egress word read -> tready=1 the next cycle, no data lost across pointer wrap.
